// File: rtl/gpr_pkg.sv
// Shared encodings for the GPR bus sequencer and the instruction decoder:
// op codes, register-file select codes, sequencer states and select decode.
package gpr_pkg;

  typedef enum logic [1:0] {
    OP_MOV   = 2'b00,
    OP_SWAP  = 2'b01,
    OP_LDI   = 2'b10,
    OP_PCINC = 2'b11
  } gpr_op_e;

  localparam logic [2:0] SEL_R0  = 3'b000;
  localparam logic [2:0] SEL_PC  = 3'b001;
  localparam logic [2:0] SEL_RD1 = 3'b010;
  localparam logic [2:0] SEL_RD2 = 3'b011;
  localparam logic [2:0] SEL_RS1 = 3'b100;
  localparam logic [2:0] SEL_RS2 = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_WR_A,
    ST_WR_B
  } gpr_state_e;

  function automatic logic gpr_is_read(input gpr_state_e st);
    return (st == ST_RD_A) || (st == ST_RD_B);
  endfunction

  function automatic logic gpr_is_write(input gpr_state_e st);
    return (st == ST_WR_A) || (st == ST_WR_B);
  endfunction

  // PCINC routes both of its bus cycles through R7; everything else uses Rs/Rd.
  function automatic logic [2:0] gpr_sel_for(input gpr_state_e st, input gpr_op_e op_code);
    logic [2:0] sel;
    sel = SEL_R0;
    case (st)
      ST_RD_A: sel = (op_code == OP_PCINC) ? SEL_PC : SEL_RS1;
      ST_RD_B: sel = SEL_RD1;
      ST_WR_A: sel = (op_code == OP_PCINC) ? SEL_PC : SEL_RD1;
      ST_WR_B: sel = SEL_RS1;
      default: sel = SEL_R0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bus_tristate_driver.sv
// WIDTH-bit tri-state bus driver: drives io_bus from i_data while i_en is
// high, otherwise releases the bus to high-Z for other masters.
module bus_tristate_driver #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  inout  tri logic [WIDTH-1:0] io_bus
);

  assign io_bus = i_en ? i_data : {WIDTH{1'bz}};

endmodule

// File: rtl/gpr_bus_sequencer.sv
// Register-file micro-op sequencer: runs MOV/SWAP/LDI/PCINC as a series of
// single-cycle read/write bus cycles through internal temporaries.
module gpr_bus_sequencer
  import gpr_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [2:0]       dst,
  input  logic [2:0]       src,
  input  logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic             done,
  inout  tri logic [WIDTH-1:0] DATA,
  output logic             GPR_in,
  output logic             GPR_out,
  output logic [2:0]       GPR_select,
  output logic [2:0]       Rd_1,
  output logic [2:0]       Rs_1
);

  gpr_state_e       r_state;
  gpr_state_e       w_state_nxt;
  gpr_op_e          r_op;
  gpr_op_e          w_op_in;
  gpr_op_e          w_op_eff;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_tmp_a;
  logic [WIDTH-1:0] r_tmp_b;
  logic [2:0]       r_rd;
  logic [2:0]       r_rs;
  logic             r_busy;
  logic             r_done;
  logic             r_gin;
  logic             r_gout;
  logic [2:0]       r_sel;
  logic             r_drv;
  logic             w_accept;
  logic [WIDTH-1:0] w_wdata;

  assign w_op_in  = gpr_op_e'(op);
  assign w_accept = (r_state == ST_IDLE) && start;
  // In IDLE the op has not been captured yet, so decode from the live input.
  assign w_op_eff = (r_state == ST_IDLE) ? w_op_in : r_op;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = (w_op_in == OP_LDI) ? ST_WR_A : ST_RD_A;
      ST_RD_A: w_state_nxt = (r_op == OP_SWAP) ? ST_RD_B : ST_WR_A;
      ST_RD_B: w_state_nxt = ST_WR_A;
      ST_WR_A: w_state_nxt = (r_op == OP_SWAP) ? ST_WR_B : ST_IDLE;
      ST_WR_B: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes, select and drive enable are decoded from the next state and
  // registered, so they change on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gin   <= 1'b0;
      r_gout  <= 1'b0;
      r_sel   <= SEL_R0;
      r_drv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_IDLE) && (r_state != ST_IDLE);
      r_gin   <= gpr_is_write(w_state_nxt);
      r_gout  <= gpr_is_read(w_state_nxt);
      r_sel   <= gpr_sel_for(w_state_nxt, w_op_eff);
      r_drv   <= gpr_is_write(w_state_nxt);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= OP_MOV;
      r_imm   <= '0;
      r_rd    <= '0;
      r_rs    <= '0;
      r_tmp_a <= '0;
      r_tmp_b <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= w_op_in;
        r_imm <= imm;
        r_rd  <= dst;
        r_rs  <= src;
      end
      if (r_state == ST_RD_A) r_tmp_a <= DATA;
      if (r_state == ST_RD_B) r_tmp_b <= DATA;
    end
  end

  always_comb begin
    w_wdata = r_tmp_b;
    if (r_state == ST_WR_A) begin
      case (r_op)
        OP_LDI:   w_wdata = r_imm;
        OP_PCINC: w_wdata = r_tmp_a + WIDTH'(1);
        default:  w_wdata = r_tmp_a;
      endcase
    end
  end

  bus_tristate_driver #(
    .WIDTH (WIDTH)
  ) u_bus_drv (
    .i_en   (r_drv),
    .i_data (w_wdata),
    .io_bus (DATA)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign GPR_in     = r_gin;
  assign GPR_out    = r_gout;
  assign GPR_select = r_sel;
  assign Rd_1       = r_rd;
  assign Rs_1       = r_rs;

  a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(GPR_in && GPR_out));
  a_done_idle:   assert property (@(posedge clk) disable iff (reset) !(done && busy));
  a_idle_sel:    assert property (@(posedge clk) disable iff (reset) !busy |-> (GPR_select == SEL_R0));

endmodule

// File: doc/gpr_bus_sequencer.md
# gpr_bus_sequencer

Control-side partner of the general-purpose register file: a small FSM that drives the register file's `GPR_in`/`GPR_out`/`GPR_select` strobes and the shared 16-bit `DATA` bus to execute register-level micro-operations. The four operations are move, swap, load-immediate and PC increment. Register-to-register transfers go through internal temporaries, because the register file forbids simultaneous in/out. It sits between the instruction decoder, which issues requests, and the register file on the CPU datapath bus.

## Interface
Parameters:
- `WIDTH`, 16, bus and register width.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high; forces IDLE immediately.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  2  operation, captured on accept: 00 MOV, 01 SWAP, 10 LDI, 11 PCINC.
- `dst`  in  3  destination register index, captured on accept.
- `src`  in  3  source register index, captured on accept.
- `imm`  in  WIDTH  immediate for LDI, captured on accept.
- `busy`  out  1  high from the cycle after accept through the last bus cycle.
- `done`  out  1  one-cycle pulse, in IDLE, after the final write edge.
- `DATA`  inout  WIDTH  shared bus; driven only in write states, else high-Z.
- `GPR_in`  out  1  register-file latch strobe.
- `GPR_out`  out  1  register-file output-enable strobe.
- `GPR_select`  out  3  000 R0, 001 R7/PC, 010 Rd_1, 100 Rs_1; other codes are never driven.
- `Rd_1`  out  3  captured `dst`.
- `Rs_1`  out  3  captured `src`.

## Operation
- States: IDLE, RD_A, RD_B, WR_A, WR_B. Each non-IDLE state is exactly one bus cycle.
- IDLE with `start`=1: capture `op`/`dst`/`src`/`imm` and go to the op's first state. `start` is ignored while `busy`.
- Read state: `GPR_out`=1, `GPR_in`=0, DATA high-Z. The register drives the bus; TMP_A or TMP_B captures DATA at the posedge.
- Write state: `GPR_in`=1, `GPR_out`=0. The sequencer drives DATA from a temporary, an incremented temporary, or the immediate; the register latches at the posedge.
- `GPR_in` and `GPR_out` are never both 1. In IDLE both are 0 and `GPR_select`=000.
- MOV: RD_A (sel 100, TMP_A←Rs) → WR_A (sel 010, drive TMP_A).
- SWAP: RD_A (100, TMP_A←Rs) → RD_B (010, TMP_B←Rd) → WR_A (010, drive TMP_A) → WR_B (100, drive TMP_B).
- LDI: WR_A (010, drive captured `imm`).
- PCINC: RD_A (001, TMP_A←PC) → WR_A (001, drive TMP_A+1, modulo 2^WIDTH).
- Register-index rules:
  - `dst`=0 writes are performed on the bus and are discarded by R0.
  - Reads of R0 return 0.
  - SWAP with `dst`==`src` runs all four cycles and leaves the register unchanged.
- Reset:
  - Asynchronous; may occur mid-op.
  - Forces IDLE, `busy`=0, `done`=0, `GPR_in`=`GPR_out`=0, `GPR_select`=000, `Rd_1`=`Rs_1`=0, TMP_A=TMP_B=0, DATA high-Z.
  - The aborted op's partial writes stand; no rollback.

## Timing
- Accept edge = cycle 0. Op states occupy cycles 1..N; `done` is high in cycle N+1.
- N (bus cycles) per op: MOV 2, SWAP 4, LDI 1, PCINC 2.
- `done` is registered, high for exactly one cycle, with `busy`=0 in that cycle.
- A `start` in the `done` cycle is accepted, giving back-to-back ops with no idle bubble.
- `busy`, strobes, selects and the DATA drive enable are registered outputs decoded from state. No combinational path from inputs to outputs.
- DATA drive enable is asserted only in WR_A/WR_B and deasserts in the same cycle the state leaves them.

## Structure
- Shared package `gpr_pkg` holds:
  - op encodings (OP_MOV, OP_SWAP, OP_LDI, OP_PCINC);
  - GPR_select codes (SEL_R0, SEL_PC, SEL_RD1, SEL_RD2, SEL_RS1, SEL_RS2);
  - the state enum.
- The decoder reuses these same constants.
- One sub-module is natural: `bus_tristate_driver`, the WIDTH-bit tri-state with enable, reusable by other bus masters.

## Test plan
- Reset, then LDI `dst`=3, `imm`=16'hBEEF → one write cycle with sel 010, `Rd_1`=3, DATA=BEEF; `done` in cycle 2; R3=BEEF.
- R2=1234, then MOV `src`=2, `dst`=5 → cycle 1 `GPR_out` sel 100; cycle 2 `GPR_in` sel 010 with DATA=1234; R5=1234; `done` in cycle 3.
- R4=AAAA, R6=5555, then SWAP `src`=4, `dst`=6 → R4=5555, R6=AAAA, `done` in cycle 5. Repeat with `src`=`dst`=4 → R4 unchanged.
- PC=FFFF, then PCINC → PC=0000 (wrap); strobes never both high; DATA high-Z during RD_A.
- Assert reset in cycle 2 of a SWAP → all outputs at reset values immediately, no further writes, next LDI works normally.
- Assert `start` during `busy` → ignored. A new `start` in the `done` cycle → accepted with no gap.
